imem_prog_server: RTL and testbench
===================================

// Module: imem_prog_server
// PURPOSE
//  Instruction-memory responder for the single-cycle RV32 core: the memory side of the imem_addr/imem_out fetch port.
//  A bench or boot master streams a program in over a valid/ready load port. After a run command the block serves
//  imem_out = word at imem_addr combinationally, with the same-cycle fetch timing the core expects.
//  Replaces hand-driven imem_out in instruction benches.
// PARAMETERS
//  DEPTH      256            program words stored (power of 2)
//  AW         $clog2(DEPTH)  word-index width
//  NOP_INSTR  32'h0000_0013  word returned for empty/out-of-range/faulted fetches (addi x0,x0,0)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      synchronous, active-LOW reset (rst==0 resets on the clk edge)
//  ld_start     in   1      1-cycle pulse: (re)start a program load, from any state
//  ld_valid     in   1      load word valid
//  ld_data      in   32     load word
//  ld_last      in   1      qualifies the final word, sampled with ld_valid
//  ld_ready     out  1      load word accepted this cycle when ld_valid && ld_ready
//  run          in   1      1-cycle pulse: LOADED -> RUN
//  imem_addr    in   32     byte fetch address from the core
//  imem_out     out  32     fetched instruction (combinational)
//  loaded_words out  AW+1   words held by the current program
//  loaded       out  1      state is LOADED or RUN
//  fault        out  1      sticky misaligned-fetch flag
//  fetch_cnt    out  32     valid fetches in RUN (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, wptr=0, loaded_words=0, fault=0, fetch_cnt=0, ld_ready=0, loaded=0, imem_out=NOP_INSTR.
//  RAM contents are not reset.
//  FSM states: IDLE, LOAD, LOADED, RUN, FAULT.
//   any --ld_start--> LOAD: wptr=0, loaded_words=0, fault=0, fetch_cnt=0. ld_start takes priority over every other event.
//   LOAD: ld_ready = !ld_start. On an accepted word: mem[wptr] <= ld_data, wptr++, loaded_words++.
//     Accepted word with ld_last=1, or accepted word at wptr==DEPTH-1 -> LOADED (ld_ready=0 next cycle).
//     A word cannot be written beyond DEPTH and wptr never wraps. run is ignored in LOAD.
//   LOADED --run--> RUN. run is ignored in IDLE, LOAD, RUN and FAULT.
//   RUN: when imem_addr[1:0]!=0, next state is FAULT and fault<=1.
//   FAULT: exits only via ld_start or reset.
//  Read path, combinational, zero latency:
//   In RUN with imem_addr[1:0]==0 and idx=imem_addr[AW+1:2] < loaded_words: imem_out = mem[idx].
//   In every other case, including the misaligned cycle itself and all of FAULT: imem_out = NOP_INSTR.
//   Address bits above AW+1 must be 0 to count as in range; nonzero upper bits give NOP_INSTR.
//  Out-of-range aligned fetches return NOP_INSTR and are not a fault.
//  Zero-length load is impossible: the first accepted word always counts.
//  Reset mid-load: program is discarded (loaded_words=0) and ld_ready drops on the next cycle.
// CONFIGURATION
//  IMEM_FETCH_CNT_EN defined: fetch_cnt increments once per RUN cycle with an aligned, in-range imem_addr.
//   It saturates at 32'hFFFF_FFFF and clears on reset or ld_start.
//  IMEM_FETCH_CNT_EN undefined: fetch_cnt is tied to 32'd0 and no counter logic is synthesised. The port still exists.
// STRUCTURE
//  Package imem_pkg: enum imem_state_e {IDLE, LOAD, LOADED, RUN, FAULT}; localparam NOP_INSTR_DEFAULT = 32'h0000_0013.
//  Sub-module imem_ram: DEPTH x 32, one synchronous write port, one asynchronous read port.
//  The top level holds the FSM, wptr, the range/alignment check and the fetch counter.
// TESTING
//  1 Load 32'h0000_0093, 32'h0000_0113, 32'h0020_e1b3 (ld_last on the 3rd word), then pulse run -> loaded_words=3, loaded=1.
//    Fetches at imem_addr 0, 4, 8, 12 return 0x00000093, 0x00000113, 0x0020e1b3, 0x00000013.
//  2 Before run (LOADED), imem_addr=0 -> imem_out=0x00000013. A run pulse during LOAD is ignored.
//  3 In RUN, imem_addr=0x2 -> same cycle imem_out=0x13. Next cycle fault=1, state FAULT.
//    A later fetch at addr 0 still returns 0x13. ld_start clears fault.
//  4 Stream 256 words with no ld_last -> after the 256th accept ld_ready=0 and loaded_words=256.
//    A 257th ld_valid is not accepted, and fetch 0x3FC returns word 255.
//  5 Drive rst=0 after 2 of 3 words -> next cycle loaded_words=0, ld_ready=0, imem_out=0x13.
//    ld_start asserted together with an ld_valid word in LOAD -> that word is not accepted and wptr=0.
//  6 With IMEM_FETCH_CNT_EN: scenario 1 run -> fetch_cnt=3 (the addr-12 fetch is not counted).
//    Without the macro -> fetch_cnt stays 0.

Source files
------------

// File: rtl/imem_prog_server_pkg.sv
// Shared types for the instruction-memory program server: FSM states and the default fill word.
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOADED,
    RUN,
    FAULT
  } imem_state_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/imem_prog_server_if.sv
// Load port (valid/ready program stream plus start/run pulses) and core fetch port.
interface imem_prog_server_if;

  logic        ld_start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        run;
  logic [31:0] imem_addr;
  logic [31:0] imem_out;

  modport master (
    output ld_start, ld_valid, ld_data, ld_last, run, imem_addr,
    input  ld_ready, imem_out
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last, run, imem_addr,
    output ld_ready, imem_out
  );

endinterface

// File: rtl/imem_prog_server_ram.sv
// Program store: DEPTH x 32, one synchronous write port, one asynchronous read port.
// Zero read latency; no backpressure. Contents are deliberately not reset.
module imem_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_prog_server.sv
// Instruction-memory responder: streams a program in, then serves imem_out = mem[imem_addr] (fetch_cnt via IMEM_FETCH_CNT_EN).
// Latency: fetch path is combinational, zero cycles; load words are written on the accepting edge.
// Backpressure: ld_ready is high only in LOAD without a concurrent ld_start; full or ld_last ends the load.
import imem_pkg::*;

module imem_prog_server #(
  parameter int          DEPTH     = 256,
  parameter int          AW        = $clog2(DEPTH),
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_prog_server_if.slave    bus,
  output logic [AW:0]          loaded_words,
  output logic                 loaded,
  output logic                 fault,
  output logic [31:0]          fetch_cnt
);

  imem_state_e   state_q, state_d;
  logic [AW:0]   wptr_q;
  logic [AW-1:0] ridx;
  logic [31:0]   rd_word;
  logic          accept;
  logic          aligned;
  logic          in_range;
  logic          hit;
  logic          last_slot;

  assign ridx      = bus.imem_addr[AW+1:2];
  assign aligned   = (bus.imem_addr[1:0] == 2'b00);
  // Upper address bits must be zero, otherwise the index would alias into the store.
  assign in_range  = (bus.imem_addr[31:AW+2] == '0) && ({1'b0, ridx} < wptr_q);
  assign hit       = (state_q == RUN) && aligned && in_range;
  assign last_slot = (wptr_q == (AW+1)'(DEPTH - 1));

  assign bus.ld_ready = (state_q == LOAD) && !bus.ld_start;
  assign accept       = bus.ld_valid && bus.ld_ready;
  assign bus.imem_out = hit ? rd_word : NOP_INSTR;
  assign loaded       = (state_q == LOADED) || (state_q == RUN);
  assign loaded_words = wptr_q;

  always_comb begin
    state_d = state_q;
    if (bus.ld_start) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD:    if (accept && (bus.ld_last || last_slot)) state_d = LOADED;
        LOADED:  if (bus.run) state_d = RUN;
        RUN:     if (!aligned) state_d = FAULT;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.ld_start) begin
        wptr_q <= '0;
        fault  <= 1'b0;
      end else begin
        if (accept) begin
          wptr_q <= wptr_q + (AW+1)'(1);
        end
        if ((state_q == RUN) && !aligned) begin
          fault <= 1'b1;
        end
      end
    end
  end

`ifdef IMEM_FETCH_CNT_EN
  logic [31:0] fetch_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
    end else if (bus.ld_start) begin
      fetch_cnt_q <= '0;
    end else if (hit && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
`else
  assign fetch_cnt = 32'd0;
`endif

  imem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wptr_q[AW-1:0]),
    .wdata (bus.ld_data),
    .raddr (ridx),
    .rdata (rd_word)
  );

endmodule

// File: tb/tb_imem_prog_server.sv
// Randomized bench for imem_prog_server against a word-count/mode reference model, plus directed scenarios.
module tb_imem_prog_server;

  localparam int          DEPTH = 256;
  localparam int          AW    = 8;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  localparam int M_IDLE = 0, M_LOAD = 1, M_LOADED = 2, M_RUN = 3, M_FAULT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_prog_server_if bus ();

  logic [AW:0] loaded_words;
  logic        loaded;
  logic        fault;
  logic [31:0] fetch_cnt;

  imem_prog_server #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .loaded_words (loaded_words),
    .loaded       (loaded),
    .fault        (fault),
    .fetch_cnt    (fetch_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode, number of words held, sticky fault, fetch count, stored words.
  int          mode    = M_IDLE;
  int          nwords  = 0;
  bit          m_fault = 1'b0;
  logic [31:0] m_fetch = 32'd0;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] prog  [DEPTH];

  function automatic logic [31:0] m_out();
    logic [31:0] a;
    a = bus.imem_addr;
    if (mode == M_RUN && a % 4 == 0 && a / 4 < nwords) return m_mem[a / 4];
    return NOP;
  endfunction

  task automatic m_step();
    logic [31:0] a;
    a = bus.imem_addr;
    if (!rst) begin
      mode = M_IDLE; nwords = 0; m_fault = 1'b0; m_fetch = 32'd0;
    end else if (bus.ld_start) begin
      mode = M_LOAD; nwords = 0; m_fault = 1'b0; m_fetch = 32'd0;
    end else if (mode == M_LOAD) begin
      if (bus.ld_valid) begin
        m_mem[nwords] = bus.ld_data;
        nwords++;
        if (bus.ld_last || nwords == DEPTH) mode = M_LOADED;
      end
    end else if (mode == M_LOADED) begin
      if (bus.run) mode = M_RUN;
    end else if (mode == M_RUN) begin
      if (a % 4 != 0) begin
        mode = M_FAULT;
        m_fault = 1'b1;
      end
`ifdef IMEM_FETCH_CNT_EN
      else if (a / 4 < nwords && m_fetch != 32'hFFFF_FFFF) begin
        m_fetch++;
      end
`endif
    end
  endtask

  // One clock: compare all outputs mid-cycle, then advance the model on the edge.
  task automatic cycle();
    @(negedge clk);
    check("ld_ready", 32'(bus.ld_ready), 32'(mode == M_LOAD && !bus.ld_start));
    check("imem_out", bus.imem_out, m_out());
    check("loaded_words", 32'(loaded_words), 32'(nwords));
    check("loaded", 32'(loaded), 32'(mode == M_LOADED || mode == M_RUN));
    check("fault", 32'(fault), 32'(m_fault));
    check("fetch_cnt", fetch_cnt, m_fetch);
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic load_prog(input int n, input bit use_last, input int gap, input bit poke_run);
    int i = 0;
    int guard = 0;
    bus.ld_start = 1'b1;
    cycle();
    bus.ld_start = 1'b0;
    while (i < n && guard < 8 * DEPTH) begin
      guard++;
      bus.ld_valid = ($urandom_range(99) >= gap);
      bus.ld_data  = prog[i];
      bus.ld_last  = use_last && (i == n - 1);
      bus.run      = poke_run && (i == 0);
      cycle();
      if (bus.ld_valid) i++;
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    bus.run      = 1'b0;
    if (i < n) check("load_guard", 32'(i), 32'(n));
  endtask

  task automatic pulse_run();
    bus.run = 1'b1;
    cycle();
    bus.run = 1'b0;
  endtask

  task automatic fetch_expect(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.imem_addr = addr;
    #1;
    check(tag, bus.imem_out, exp);
    cycle();
  endtask

  initial begin
    rst           = 1'b0;
    bus.ld_start  = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = 32'd0;
    bus.ld_last   = 1'b0;
    bus.run       = 1'b0;
    bus.imem_addr = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("rst_words", 32'(loaded_words), 32'd0);
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fetch_cnt", fetch_cnt, 32'd0);
    check("rst_imem_out", bus.imem_out, NOP);
    cycle();
    rst = 1'b1;
    cycle();

    // Three-word program with a run pulse during LOAD that must be ignored.
    prog[0] = 32'h0000_0093;
    prog[1] = 32'h0000_0113;
    prog[2] = 32'h0020_e1b3;
    load_prog(3, 1'b1, 0, 1'b1);
    check("t1_words", 32'(loaded_words), 32'd3);
    check("t1_loaded", 32'(loaded), 32'd1);
    fetch_expect("t2_loaded_fetch", 32'd0, NOP);
    pulse_run();
    fetch_expect("t1_fetch0", 32'd0, 32'h0000_0093);
    fetch_expect("t1_fetch4", 32'd4, 32'h0000_0113);
    fetch_expect("t1_fetch8", 32'd8, 32'h0020_e1b3);
    fetch_expect("t1_fetch12", 32'd12, NOP);
`ifdef IMEM_FETCH_CNT_EN
    check("t6_fetch_cnt", fetch_cnt, 32'd3);
`else
    check("t6_fetch_cnt", fetch_cnt, 32'd0);
`endif

    // Misaligned fetch faults; fault is sticky until ld_start.
    fetch_expect("t3_misaligned", 32'd2, NOP);
    check("t3_fault", 32'(fault), 32'd1);
    fetch_expect("t3_after_fault", 32'd0, NOP);
    bus.ld_start = 1'b1;
    cycle();
    bus.ld_start = 1'b0;
    check("t3_fault_clr", 32'(fault), 32'd0);

    // Full-depth load without ld_last.
    for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
    load_prog(DEPTH, 1'b0, 20, 1'b0);
    check("t4_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("t4_words", 32'(loaded_words), 32'd256);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'hDEAD_BEEF;
    cycle();
    bus.ld_valid = 1'b0;
    check("t4_no_257th", 32'(loaded_words), 32'd256);
    pulse_run();
    fetch_expect("t4_last_word", 32'h0000_03FC, prog[255]);
    fetch_expect("t4_first_word", 32'h0000_0000, prog[0]);
    fetch_expect("t4_past_end", 32'h0000_0400, NOP);
    fetch_expect("t4_upper_bits", 32'h1000_0000, NOP);

    // Reset in the middle of a load.
    bus.ld_start = 1'b1;
    cycle();
    bus.ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = $urandom;
      cycle();
    end
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    bus.ld_valid = 1'b0;
    bus.imem_addr = 32'd0;
    #1;
    check("t5_words", 32'(loaded_words), 32'd0);
    check("t5_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("t5_imem_out", bus.imem_out, NOP);
    cycle();

    // ld_start beats a concurrent ld_valid in LOAD.
    bus.ld_start = 1'b1;
    cycle();
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'h1234_5678;
    #1;
    check("t5_start_blocks_rdy", 32'(bus.ld_ready), 32'd0);
    cycle();
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    check("t5_start_wptr", 32'(loaded_words), 32'd0);

    // Randomized programs and fetch streams.
    for (int it = 0; it < 24; it++) begin
      int n;
      n = ($urandom_range(7) == 0) ? DEPTH : int'($urandom_range(1, 40));
      for (int i = 0; i < n; i++) prog[i] = $urandom;
      load_prog(n, (n != DEPTH) || ($urandom_range(1) == 1), 30, 1'b1);
      for (int k = 0; k < 3; k++) begin
        bus.imem_addr = 4 * $urandom_range(0, n - 1);
        cycle();
      end
      pulse_run();
      for (int k = 0; k < 50; k++) begin
        int r;
        r = $urandom_range(99);
        if (r < 70)      bus.imem_addr = 4 * $urandom_range(0, n - 1);
        else if (r < 85) bus.imem_addr = 4 * $urandom_range(n, DEPTH + 8);
        else if (r < 92) bus.imem_addr = {$urandom, 2'b00} ;
        else if (r < 95) bus.imem_addr = $urandom | 32'd1;
        else             bus.imem_addr = 4 * $urandom_range(0, n - 1) + 2;
        if ($urandom_range(99) < 2) rst = 1'b0;
        cycle();
        rst = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
